// File: rtl/disc_stage_sequencer.sv
// Frame loader, in-order N-stage start/done sequencer with per-stage watchdog, and {decision,score} FIFO.
// Optional build macro DISC_THRESHOLD_EN: decision is score >= score_threshold instead of final_decision.

module disc_stage_sequencer #(
  parameter int DATA_W         = 16,
  parameter int SAMPLE_COUNT   = 256,
  parameter int NUM_STAGES     = 3,
  parameter int SCORE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 cont_mode,
  input  logic                                 sample_valid,
  input  logic [DATA_W-1:0]                    sample_data,
  output logic                                 sample_ready,
  output logic [DATA_W*SAMPLE_COUNT-1:0]       sample_buf,
  output logic [NUM_STAGES-1:0]                stage_start,
  input  logic [NUM_STAGES-1:0]                stage_done,
  input  logic [DATA_W-1:0]                    final_score,
  input  logic                                 final_decision,
`ifdef DISC_THRESHOLD_EN
  input  logic [DATA_W-1:0]                    score_threshold,
`endif
  input  logic                                 score_rd_en,
  output logic [DATA_W:0]                      score_rd_data,
  output logic                                 score_rd_valid,
  output logic                                 score_empty,
  output logic [$clog2(SCORE_DEPTH+1)-1:0]     score_level,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 timeout_err,
  output logic [$clog2(NUM_STAGES+1)-1:0]      err_stage,
  output logic [15:0]                          real_count
);

  localparam int IDX_W = $clog2(SAMPLE_COUNT);
  localparam int ST_W  = $clog2(NUM_STAGES + 1);
  localparam int PTR_W = $clog2(SCORE_DEPTH);
  localparam int LVL_W = $clog2(SCORE_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENT_W = DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [ST_W-1:0]                stg_q, stg_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic [DATA_W*SAMPLE_COUNT-1:0] buf_q, buf_d;
  logic [NUM_STAGES-1:0]          stage_start_q, stage_start_d;
  logic [DATA_W-1:0]              cap_score_q, cap_score_d;
  logic                           cap_dec_q, cap_dec_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           terr_q, terr_d;
  logic [ST_W-1:0]                err_stage_q, err_stage_d;
  logic [15:0]                    real_q, real_d;
  logic [ENT_W-1:0]               mem_q [SCORE_DEPTH];
  logic [ENT_W-1:0]               mem_d [SCORE_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]               level_q, level_d;
  logic [ENT_W-1:0]               rd_data_q, rd_data_d;
  logic                           rd_valid_q, rd_valid_d;
  logic                           full, push, pop, new_dec;

`ifdef DISC_THRESHOLD_EN
  logic unused_final_decision;
  assign unused_final_decision = final_decision;
  assign new_dec = ($signed(final_score) >= $signed(score_threshold));
`else
  assign new_dec = final_decision;
`endif

  assign full = (level_q == LVL_W'(SCORE_DEPTH));
  assign pop  = score_rd_en && (level_q != {LVL_W{1'b0}});

  // Next-state for the sequencer FSM, watchdog, score FIFO and registered outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stg_d         = stg_q;
    wd_d          = wd_q;
    buf_d         = buf_q;
    stage_start_d = {NUM_STAGES{1'b0}};
    cap_score_d   = cap_score_q;
    cap_dec_d     = cap_dec_q;
    done_d        = 1'b0;
    terr_d        = terr_q;
    err_stage_d   = err_stage_q;
    real_d        = real_q;
    push          = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A full FIFO blocks the frame start; start is not remembered
        if ((start || cont_mode) && !full) begin
          state_d = S_LOAD;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (sample_valid) begin
          buf_d[idx_q*DATA_W +: DATA_W] = sample_data;
          if (idx_q == IDX_W'(SAMPLE_COUNT - 1)) begin
            state_d       = S_RUN;
            stg_d         = {ST_W{1'b0}};
            wd_d          = {WD_W{1'b0}};
            stage_start_d = NUM_STAGES'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_RUN: begin
        // A done arriving in the same cycle the watchdog expires takes priority
        if (stage_done[stg_q]) begin
          if (stg_q == ST_W'(NUM_STAGES - 1)) begin
            cap_score_d = final_score;
            cap_dec_d   = new_dec;
            state_d     = S_WRITE;
          end else begin
            stg_d         = stg_q + ST_W'(1);
            wd_d          = {WD_W{1'b0}};
            stage_start_d = NUM_STAGES'(1) << (stg_q + ST_W'(1));
          end
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_ERR;
          terr_d      = 1'b1;
          err_stage_d = stg_q;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_WRITE: begin
        if (!full) begin
          push    = 1'b1;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_FIN: begin
        if (cap_dec_q && (real_q != 16'hFFFF)) begin
          real_d = real_q + 16'd1;
        end else begin
          real_d = real_q;
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          terr_d      = 1'b0;
          err_stage_d = {ST_W{1'b0}};
          state_d     = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_WRITE);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cap_dec_q, cap_score_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_data_d = rd_data_q;
      rd_ptr_d  = rd_ptr_q;
    end
    rd_valid_d = pop;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= {IDX_W{1'b0}};
      stg_q         <= {ST_W{1'b0}};
      wd_q          <= {WD_W{1'b0}};
      buf_q         <= {(DATA_W*SAMPLE_COUNT){1'b0}};
      stage_start_q <= {NUM_STAGES{1'b0}};
      cap_score_q   <= {DATA_W{1'b0}};
      cap_dec_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      terr_q        <= 1'b0;
      err_stage_q   <= {ST_W{1'b0}};
      real_q        <= 16'd0;
      for (int i = 0; i < SCORE_DEPTH; i++) mem_q[i] <= {ENT_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      level_q       <= {LVL_W{1'b0}};
      rd_data_q     <= {ENT_W{1'b0}};
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stg_q         <= stg_d;
      wd_q          <= wd_d;
      buf_q         <= buf_d;
      stage_start_q <= stage_start_d;
      cap_score_q   <= cap_score_d;
      cap_dec_q     <= cap_dec_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      terr_q        <= terr_d;
      err_stage_q   <= err_stage_d;
      real_q        <= real_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign sample_ready   = (state_q == S_LOAD);
  assign sample_buf     = buf_q;
  assign stage_start    = stage_start_q;
  assign score_rd_data  = rd_data_q;
  assign score_rd_valid = rd_valid_q;
  assign score_empty    = (level_q == {LVL_W{1'b0}});
  assign score_level    = level_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = terr_q;
  assign err_stage      = err_stage_q;
  assign real_count     = real_q;

endmodule

// File: tb/tb_disc_stage_sequencer.sv
// Bench for disc_stage_sequencer: stage responder model, FIFO scoreboard, per-scenario check tasks.

module tb_disc_stage_sequencer;
  localparam int DW = 16;
  localparam int SC = 256;
  localparam int NS = 3;
  localparam int SD = 4;
  localparam int TO = 20;
  localparam int LW = $clog2(SD + 1);
  localparam int SW = $clog2(NS + 1);

  logic clk, rst, start, cont_mode, sample_valid, sample_ready;
  logic [DW-1:0] sample_data, final_score;
  logic [DW*SC-1:0] sample_buf;
  logic [NS-1:0] stage_start, stage_done;
  logic final_decision, score_rd_en, score_rd_valid, score_empty, busy, done, timeout_err;
  logic [DW:0] score_rd_data;
  logic [LW-1:0] score_level;
  logic [SW-1:0] err_stage;
  logic [15:0] real_count;
`ifdef DISC_THRESHOLD_EN
  logic [DW-1:0] score_threshold;
`endif

  int vectors = 0, errors = 0, cyc = 0, done_cnt = 0;
  int st0_cyc = 0, st1_cyc = 0, last_done_cyc = 0, terr_cyc = 0;
  bit terr_seen = 1'b0;
  int resp_dly = 10, hang_stage = -1, exp_real = 0;
  int cnt [NS];
  logic [DW:0] resp_q [$];
  logic [DW:0] exp_q [$];
  logic [DW-1:0] exp_buf [SC];

  disc_stage_sequencer #(.DATA_W(DW), .SAMPLE_COUNT(SC), .NUM_STAGES(NS), .SCORE_DEPTH(SD),
                         .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .sample_buf(sample_buf), .stage_start(stage_start), .stage_done(stage_done),
    .final_score(final_score), .final_decision(final_decision),
`ifdef DISC_THRESHOLD_EN
    .score_threshold(score_threshold),
`endif
    .score_rd_en(score_rd_en), .score_rd_data(score_rd_data), .score_rd_valid(score_rd_valid),
    .score_empty(score_empty), .score_level(score_level), .busy(busy), .done(done),
    .timeout_err(timeout_err), .err_stage(err_stage), .real_count(real_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stage responder: done[i] resp_dly+1 cycles after start[i]; last stage pushes the expected FIFO entry
  initial begin
    logic [DW:0] ent;
    logic d;
    stage_done = '0; final_score = '0; final_decision = 1'b0;
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    forever begin
      @(posedge clk); #1;
      stage_done = '0;
      if (rst) begin
        for (int i = 0; i < NS; i++) cnt[i] = 0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              stage_done[i] = 1'b1;
              if (i == NS - 1) begin
                ent = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
                final_score = ent[DW-1:0];
                final_decision = ent[DW];
`ifdef DISC_THRESHOLD_EN
                d = ($signed(ent[DW-1:0]) >= $signed(score_threshold));
`else
                d = ent[DW];
`endif
                exp_q.push_back({d, ent[DW-1:0]});
                if (d) exp_real++;
              end
            end
          end
          if (stage_start[i] && i != hang_stage) cnt[i] = resp_dly;
        end
      end
    end
  end

  // Event monitor, sampled between the edges
  initial begin
    forever begin
      @(posedge clk); #2;
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (stage_start[0]) st0_cyc = cyc;
      if (stage_start[1]) st1_cyc = cyc;
      if (timeout_err && !terr_seen) begin terr_seen = 1'b1; terr_cyc = cyc; end
      else if (!timeout_err) terr_seen = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed_words(input int seed, input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 4*SC + 400) begin
      @(negedge clk);
      sample_data = DW'(seed * 257 + k);
      sample_valid = 1'b1;
      if (sample_ready) begin exp_buf[k] = sample_data; k++; end
      guard++;
    end
    @(negedge clk); sample_valid = 1'b0;
    if (k < n) begin
      vectors++; errors++;
      $display("FAIL feed_words: accepted %0d beats, wanted %0d", k, n);
    end
  endtask

  task automatic wait_done_count(input int target);
    int guard = 0;
    while (done_cnt < target && guard < 3000) begin @(negedge clk); guard++; end
    if (done_cnt < target) begin
      vectors++; errors++;
      $display("FAIL wait_done: done count %0d, wanted %0d", done_cnt, target);
    end
    @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    logic [DW:0] e = '0;
    bit have;
    have = (exp_q.size() > 0);
    if (have) e = exp_q.pop_front();
    @(negedge clk); score_rd_en = 1'b1;
    @(negedge clk); score_rd_en = 1'b0;
    vectors++;
    if (score_rd_valid !== have) begin
      errors++; $display("FAIL %s rd_valid: got %b expected %b", name, score_rd_valid, have);
    end
    if (have) begin
      vectors++;
      if (score_rd_data !== e) begin
        errors++; $display("FAIL %s rd_data: got %h expected %h", name, score_rd_data, e);
      end
    end
  endtask

  task automatic run_frame(input int seed, input logic [DW:0] ent);
    int base;
    base = done_cnt;
    resp_q.push_back(ent);
    pulse_start();
    feed_words(seed, SC);
    wait_done_count(base + 1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, sample_ready, stage_start, timeout_err, score_rd_valid} !== '0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0",
                         {busy, done, sample_ready, stage_start, timeout_err, score_rd_valid});
    end
    vectors++;
    if (score_empty !== 1'b1 || score_level !== '0) begin
      errors++; $display("FAIL reset_fifo: got empty %b level %0d expected 1/0", score_empty, score_level);
    end
    vectors++;
    if (err_stage !== '0 || real_count !== 16'd0 || sample_buf !== '0) begin
      errors++; $display("FAIL reset_regs: got err_stage %0d real %0d buf_nz %b expected 0",
                         err_stage, real_count, |sample_buf);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || sample_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy %b ready %b expected 0/0", busy, sample_ready);
    end
  endtask

  task automatic test_single_frame();
    int base;
    int bad = -1;
    base = done_cnt;
    resp_q.push_back({1'b1, 16'h0123});
    pulse_start();
    feed_words(1, SC);
    vectors++;
    if (busy !== 1'b1 || sample_ready !== 1'b0) begin
      errors++; $display("FAIL run_busy: got busy %b ready %b expected 1/0", busy, sample_ready);
    end
    wait_done_count(base + 1);
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt !== base + 1 || done !== 1'b0) begin
      errors++; $display("FAIL done_once: got %0d pulses expected 1", done_cnt - base);
    end
    vectors++;
    if (last_done_cyc - st0_cyc !== 3*(resp_dly + 1) + 1) begin
      errors++; $display("FAIL latency: got %0d cycles expected %0d", last_done_cyc - st0_cyc,
                         3*(resp_dly + 1) + 1);
    end
    for (int k = 0; k < SC; k++) if (bad < 0 && sample_buf[k*DW +: DW] !== exp_buf[k]) bad = k;
    vectors++;
    if (bad >= 0) begin
      errors++; $display("FAIL buf_word: word %0d got %h expected %h", bad, sample_buf[bad*DW +: DW],
                         exp_buf[bad]);
    end
    vectors++;
    if (score_level !== LW'(1) || real_count !== 16'(exp_real)) begin
      errors++; $display("FAIL frame_state: got level %0d real %0d expected 1/%0d", score_level,
                         real_count, exp_real);
    end
    pop_check("single_pop");
  endtask

  task automatic test_fifo_edges();
    logic [DW:0] e;
    int base;
    int guard = 0;
    pop_check("empty_pop");
    vectors++;
    if (score_level !== '0 || score_empty !== 1'b1) begin
      errors++; $display("FAIL empty_level: got %0d expected 0", score_level);
    end
    run_frame(2, {1'b1, 16'h1111});
    run_frame(3, {1'b0, 16'h8222});
    vectors++;
    if (score_level !== LW'(2)) begin
      errors++; $display("FAIL level2: got %0d expected 2", score_level);
    end
    base = done_cnt;
    resp_q.push_back({1'b1, 16'h7333});
    pulse_start();
    feed_words(4, SC);
    while (stage_done[NS-1] !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    @(negedge clk);
    score_rd_en = 1'b1;
    e = exp_q.pop_front();
    @(negedge clk);
    score_rd_en = 1'b0;
    vectors++;
    if (score_rd_valid !== 1'b1 || score_rd_data !== e || score_level !== LW'(2)) begin
      errors++; $display("FAIL push_pop: got valid %b data %h level %0d expected 1/%h/2",
                         score_rd_valid, score_rd_data, score_level, e);
    end
    wait_done_count(base + 1);
    pop_check("order_pop1");
    pop_check("order_pop2");
  endtask

  task automatic test_watchdog_edge();
    resp_dly = TO - 1;
    run_frame(5, {1'b0, 16'h4444});
    resp_dly = 10;
    vectors++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL done_wins: got timeout_err %b expected 0", timeout_err);
    end
    pop_check("edge_pop");
  endtask

  task automatic test_timeout();
    int guard = 0;
    bit bad = 1'b0;
    hang_stage = 1;
    pulse_start();
    feed_words(6, SC);
    while (!terr_seen && guard < 500) begin @(negedge clk); guard++; end
    vectors++;
    if (!terr_seen || terr_cyc - st1_cyc !== TO) begin
      errors++; $display("FAIL timeout_time: got seen %b after %0d cycles expected %0d", terr_seen,
                         terr_cyc - st1_cyc, TO);
    end
    vectors++;
    if (err_stage !== SW'(1) || busy !== 1'b0 || sample_ready !== 1'b0) begin
      errors++; $display("FAIL err_state: got stage %0d busy %b ready %b expected 1/0/0", err_stage,
                         busy, sample_ready);
    end
    repeat (5) begin @(negedge clk); if (stage_start !== '0 || busy !== 1'b0) bad = 1'b1; end
    vectors++;
    if (bad) begin errors++; $display("FAIL err_quiet: got activity 1 expected 0"); end
    hang_stage = -1;
    pulse_start();
    vectors++;
    if (timeout_err !== 1'b0 || err_stage !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_clear: got err %b stage %0d busy %b expected 0/0/0", timeout_err,
                         err_stage, busy);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit act = 1'b0;
    base = done_cnt;
    @(negedge clk); cont_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      resp_q.push_back({1'(f % 2), 16'(16'h0A00 + f * 16'h0111)});
      feed_words(10 + f, SC);
    end
    wait_done_count(base + 4);
    vectors++;
    if (score_level !== LW'(SD)) begin
      errors++; $display("FAIL cont_full: got level %0d expected %0d", score_level, SD);
    end
    resp_q.push_back({1'b1, 16'h0F0F});
    repeat (30) begin @(negedge clk); if (sample_ready || busy) act = 1'b1; end
    vectors++;
    if (act) begin errors++; $display("FAIL full_wait: got frame start 1 expected 0"); end
    pop_check("cont_pop");
    feed_words(14, SC);
    cont_mode = 1'b0;
    wait_done_count(base + 5);
    vectors++;
    if (score_level !== LW'(SD) || real_count !== 16'(exp_real)) begin
      errors++; $display("FAIL cont_refill: got level %0d real %0d expected %0d/%0d", score_level,
                         real_count, SD, exp_real);
    end
    for (int i = 0; i < SD; i++) pop_check("cont_drain");
  endtask

`ifdef DISC_THRESHOLD_EN
  task automatic test_threshold();
    score_threshold = 16'h0000;
    run_frame(20, {1'b1, 16'hFFF0});
    vectors++;
    if (exp_q.size() != 1 || exp_q[0] !== 17'h0FFF0) begin
      errors++; $display("FAIL thr_model: got %0d entries expected one 0fff0", exp_q.size());
    end
    pop_check("thr_pop");
  endtask
`endif

  task automatic test_reset_mid_load();
    pulse_start();
    feed_words(9, 100);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || sample_ready !== 1'b0 || stage_start !== '0) begin
      errors++; $display("FAIL midload_idle: got busy %b ready %b expected 0/0", busy, sample_ready);
    end
    vectors++;
    if (sample_buf !== '0 || real_count !== 16'd0 || score_level !== '0) begin
      errors++; $display("FAIL midload_clear: got buf_nz %b real %0d level %0d expected 0",
                         |sample_buf, real_count, score_level);
    end
    rst = 1'b0;
    exp_q.delete(); resp_q.delete(); exp_real = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont_mode = 1'b0; sample_valid = 1'b0; sample_data = '0;
    score_rd_en = 1'b0;
`ifdef DISC_THRESHOLD_EN
    score_threshold = '0;
`endif
    test_reset();
    test_single_frame();
    test_fifo_edges();
    test_watchdog_edge();
    test_timeout();
    test_back_to_back();
`ifdef DISC_THRESHOLD_EN
    test_threshold();
`endif
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
